ram2_delay_ctrl: RTL and testbench

Address sequencer and fill controller that turns the dual-port `ram2` into a programmable circular delay line for the sample stream. It sits between the sample source and `ram2`. On each sample strobe it drives one write and one read, and it exports the delayed sample with a valid flag. It suppresses stale RAM contents until the buffer holds the requested delay worth of samples.

---
 rtl/ram2_pkg.sv | 4 +
 rtl/ram2.sv | 24 ++
 rtl/ram2_delay_top.sv | 28 ++
 rtl/ram2_delay_ctrl.sv | 69 ++++++
 tb/tb_ram2_delay_ctrl.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/ram2_pkg.sv
// Shared types for the ram2 delay-line controller.
package ram2_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN} dly_state_t;
endpackage

// File: rtl/ram2.sv
// Simple dual-port RAM: one write port and one registered read port.
// dout holds its last read value while rd_en is low.
module ram2 #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout
);
  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDRESS_WIDTH)-1];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= din;
    if (rd_en) dout_q <= mem_q[rd_addr];
  end

  assign dout = dout_q;
endmodule

// File: rtl/ram2_delay_top.sv
// Delay line: controller plus its dual-port RAM.
module ram2_delay_top #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid
);
  logic                     wr_en, rd_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0]    ram_din, ram_dout;

  ram2_delay_ctrl #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ctrl (
    .clk(clk), .rst(rst), .en(en), .delay(delay), .din(din),
    .ram_wr_en(wr_en), .ram_rd_en(rd_en), .ram_wr_addr(wr_addr), .ram_rd_addr(rd_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .dout(dout), .dout_valid(dout_valid)
  );

  ram2 #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk(clk), .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .din(ram_din), .dout(ram_dout)
  );
endmodule

// File: rtl/ram2_delay_ctrl.sv
// Circular delay-line sequencer for ram2: one write and one read per strobe,
// with RAM output masked until delay_q samples have been written since (re)start.
module ram2_delay_ctrl
  import ram2_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic                     ram_wr_en,
  output logic                     ram_rd_en,
  output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid
);
  localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

  dly_state_t               state_q;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, delay_q, fill_cnt_q;
  logic [ADDRESS_WIDTH-1:0] delay_eff, fill_cnt_d;
  logic                     out_sel_q, dout_valid_q;

  assign delay_eff  = (delay == '0) ? ONE : delay;
  assign fill_cnt_d = fill_cnt_q + ONE;

  assign ram_wr_en   = en;
  assign ram_rd_en   = en;
  assign ram_wr_addr = wr_ptr_q;
  // delay_q >= 1 keeps the read address off the write address
  assign ram_rd_addr = wr_ptr_q - delay_q;
  assign ram_din     = din;
  assign dout        = out_sel_q ? ram_dout : '0;
  assign dout_valid  = dout_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      delay_q      <= ONE;
      fill_cnt_q   <= '0;
      out_sel_q    <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= en;
      if (en) begin
        wr_ptr_q  <= wr_ptr_q + ONE;
        out_sel_q <= 1'b0;
        if (state_q == IDLE || delay_eff != delay_q) begin
          // start or restart: the buffer must refill before reads are trusted
          delay_q    <= delay_eff;
          fill_cnt_q <= ONE;
          state_q    <= (delay_eff == ONE) ? RUN : FILL;
        end else if (state_q == FILL) begin
          fill_cnt_q <= fill_cnt_d;
          if (fill_cnt_d == delay_q) state_q <= RUN;
        end else begin
          out_sel_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ram2_delay_ctrl.sv
// Directed bench for ram2_delay_ctrl with a behavioural RAM attached to its ports.
module tb_ram2_delay_ctrl;
  localparam int AW = 9;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [AW-1:0] delay = '0;
  logic [DW-1:0] din = '0;
  logic          ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_din, dout;
  logic [DW-1:0] ram_dout = '0;
  logic          dout_valid;

  int vectors = 0;
  int miscompares = 0;
  int hist[$];

  // stale contents are a recognisable nonzero pattern so masking is visible
  logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: 8'hA5};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
    if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
  end

  ram2_delay_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .delay(delay), .din(din),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .dout(dout), .dout_valid(dout_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one cycle: drive at negedge, check controls, then outputs just after posedge
  task automatic step(input logic e, input logic [DW-1:0] d, input logic [AW-1:0] dl,
                      input logic [DW-1:0] exp, input string tag);
    @(negedge clk);
    en = e; din = d; delay = dl;
    #1;
    chk({tag, "_wr_en"}, 32'(ram_wr_en), 32'(e));
    chk({tag, "_rd_en"}, 32'(ram_rd_en), 32'(e));
    if (e) chk({tag, "_ram_din"}, 32'(ram_din), 32'(d));
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(dout_valid), 32'(e));
    chk({tag, "_dout"}, 32'(dout), 32'(exp));
  endtask

  task automatic check_addr(input logic [AW-1:0] wr, input logic [AW-1:0] rd, input string tag);
    chk({tag, "_wr_addr"}, 32'(ram_wr_addr), 32'(wr));
    chk({tag, "_rd_addr"}, 32'(ram_rd_addr), 32'(rd));
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    en = 1'b0; rst = 1'b1;
    #1;
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
    check_addr('0, '1, tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // n back-to-back strobes starting with a (re)latch of dl; output is
  // zero for the first max(dl,1) strobes, then the sample from that many strobes earlier
  task automatic run_phase(input int n, input logic [AW-1:0] dl, input string tag);
    int eff = (dl == '0) ? 1 : int'(dl);
    int start = hist.size();
    for (int j = 0; j < n; j++) begin
      logic [DW-1:0] s = DW'(hist.size() * 7 + 3) | DW'(1);
      logic [DW-1:0] exp = (j >= eff) ? DW'(hist[start + j - eff]) : '0;
      hist.push_back(int'(s));
      step(1'b1, s, dl, exp, tag);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("por_dout", 32'(dout), 32'd0);
    chk("por_valid", 32'(dout_valid), 32'd0);
    check_addr('0, '1, "por");
    rst = 1'b0;

    // delay 3, back-to-back: 0,0,0,1,2,3,4,5
    for (int k = 1; k <= 8; k++)
      step(1'b1, DW'(k), 9'd3, (k <= 3) ? '0 : DW'(k - 3), "basic");
    check_addr(9'd8, 9'd5, "basic");

    // delay 2, strobes on alternate cycles; dout holds across gaps
    reset_dut("rst_gap");
    step(1'b1, 8'd10, 9'd2, 8'd0,  "gap_s0");
    step(1'b0, 8'd0,  9'd2, 8'd0,  "gap_i0");
    step(1'b1, 8'd11, 9'd2, 8'd0,  "gap_s1");
    step(1'b0, 8'd0,  9'd2, 8'd0,  "gap_i1");
    step(1'b1, 8'd12, 9'd2, 8'd10, "gap_s2");
    step(1'b0, 8'd0,  9'd2, 8'd10, "gap_i2");
    step(1'b1, 8'd13, 9'd2, 8'd11, "gap_s3");

    // delay 4 then switch to 2 while running
    reset_dut("rst_chg");
    for (int k = 0; k < 8; k++)
      step(1'b1, DW'(20 + k), 9'd4, (k < 4) ? '0 : DW'(16 + k), "chg4");
    step(1'b1, 8'd28, 9'd2, 8'd0,  "chg2_s0");
    step(1'b1, 8'd29, 9'd2, 8'd0,  "chg2_s1");
    step(1'b1, 8'd30, 9'd2, 8'd28, "chg2_s2");
    step(1'b1, 8'd31, 9'd2, 8'd29, "chg2_s3");

    // reset while running with valid nonzero output, then refill from stale RAM
    reset_dut("rst_run");
    for (int k = 0; k < 6; k++)
      step(1'b1, DW'(40 + k), 9'd3, (k < 3) ? '0 : DW'(37 + k), "post_rst");

    // delay 0 acts as delay 1
    reset_dut("rst_d0");
    step(1'b1, 8'd50, 9'd0, 8'd0, "d0_s0");
    check_addr(9'd1, 9'd0, "d0");
    step(1'b1, 8'd51, 9'd0, 8'd50, "d0_s1");
    step(1'b1, 8'd52, 9'd0, 8'd51, "d0_s2");
    step(1'b1, 8'd53, 9'd0, 8'd52, "d0_s3");

    // maximum delay, running past the pointer wrap
    reset_dut("rst_d511");
    run_phase(600, 9'd511, "d511");
    check_addr(9'd88, 9'd89, "d511");

    // delay 5 from a running state, again across a pointer wrap
    run_phase(440, 9'd5, "d5");
    check_addr(9'd16, 9'd11, "d5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
